// File: rtl/hack_fetch_ctrl_if.sv
// Fetch-side bus bundle for hack_fetch_ctrl: instruction-ROM req/ack port
// and the valid/ready instruction port toward decode.
interface hack_fetch_ctrl_if #(
  parameter int IMEM_AW = 15
);
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_ack;
  logic [15:0]        imem_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [15:0]        instr;
  logic [15:0]        instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_data, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_data, instr_ready
  );
endinterface

// File: rtl/hack_fetch_ctrl.sv
// HACK CPU instruction-fetch sequencer: drives the PC controls, fetches one word per PC.
// Optional single-step from HALT when HACK_FETCH_STEP_EN is defined.
module hack_fetch_ctrl #(
  parameter int IMEM_AW = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic        pc_reset,
  output logic        pc_load,
  output logic        pc_increment,
  output logic [15:0] pc_target,
  input  logic        jump,
  input  logic [15:0] jump_target,
  input  logic        halt,
`ifdef HACK_FETCH_STEP_EN
  input  logic        step,
`endif
  output logic        halted,
  hack_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

  state_t      state, state_nx;
  logic        jump_pending, jump_pending_nx;
  logic [15:0] target_q, target_nx, target_sel;
  logic [15:0] instr_q, instr_pc_q;
  logic        capture, load, inc, req, leave_halt;

`ifdef HACK_FETCH_STEP_EN
  assign leave_halt = !halt || step;
`else
  assign leave_halt = !halt;
`endif

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      jump_pending <= 1'b0;
      target_q     <= '0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
    end else begin
      state        <= state_nx;
      jump_pending <= jump_pending_nx;
      target_q     <= target_nx;
      if (capture) begin
        instr_q    <= bus.imem_data;
        instr_pc_q <= pc;
      end
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx        = state;
    jump_pending_nx = jump_pending;
    target_nx       = target_q;
    target_sel      = target_q;
    capture         = 1'b0;
    load            = 1'b0;
    inc             = 1'b0;
    req             = 1'b0;

    unique case (state)
      IDLE: state_nx = halt ? HALT : FETCH;

      FETCH: begin
        req = 1'b1;
        if (bus.imem_ack) begin
          if (jump || jump_pending) begin
            // Redirect wins: the word just returned belongs to the old path.
            load            = 1'b1;
            target_sel      = jump ? jump_target : target_q;
            target_nx       = target_sel;
            jump_pending_nx = 1'b0;
          end else begin
            capture  = 1'b1;
            inc      = 1'b1;
            state_nx = HOLD;
          end
        end else if (jump) begin
          target_nx       = jump_target;
          jump_pending_nx = 1'b1;
        end
      end

      HOLD: begin
        if (jump) begin
          load       = 1'b1;
          target_sel = jump_target;
          target_nx  = jump_target;
          state_nx   = FETCH;
        end else if (bus.instr_ready) begin
          state_nx = halt ? HALT : FETCH;
        end
      end

      HALT: begin
        if (jump) begin
          load       = 1'b1;
          target_sel = jump_target;
          target_nx  = jump_target;
        end else if (leave_halt) begin
          state_nx = FETCH;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  assign pc_reset        = reset;
  assign pc_load         = load && !reset;
  assign pc_increment    = inc && !reset;
  assign pc_target       = target_sel;
  assign halted          = (state == HALT);
  assign bus.imem_req    = req && !reset;
  assign bus.imem_addr   = pc[IMEM_AW-1:0];
  assign bus.instr_valid = (state == HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_hack_fetch_ctrl.sv
// Bench for hack_fetch_ctrl: models the program counter and a variable-latency ROM,
// scoreboards delivered instructions, and walks the fetch/jump/halt/reset corners.
module tb_hack_fetch_ctrl;

  localparam int AW = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc = '0;
  logic        pc_reset, pc_load, pc_increment;
  logic [15:0] pc_target;
  logic        jump;
  logic [15:0] jump_target;
  logic        halt;
  logic        halted;
`ifdef HACK_FETCH_STEP_EN
  logic        step;
`endif

  hack_fetch_ctrl_if #(.IMEM_AW(AW)) ifc ();

  hack_fetch_ctrl #(.IMEM_AW(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .pc           (pc),
    .pc_reset     (pc_reset),
    .pc_load      (pc_load),
    .pc_increment (pc_increment),
    .pc_target    (pc_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .halt         (halt),
`ifdef HACK_FETCH_STEP_EN
    .step         (step),
`endif
    .halted       (halted),
    .bus          (ifc.master)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic        ready;
    logic        halt;
    logic        exp_req;
    logic [14:0] exp_addr;
    logic        exp_valid;
    logic        exp_inc;
    logic        exp_halted;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   total = 0;
  int   bad = 0;
  int   ack_delay = 0;
  int   wait_cnt = 0;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return (a * 16'd7) ^ 16'hC3A5;
  endfunction

  function automatic exp_t mk(input logic [15:0] a);
    exp_t e;
    e.pc   = a;
    e.data = rom(a);
    return e;
  endfunction

  // Program counter and ROM responder
  always @(posedge clock) begin
    if (pc_reset)          pc <= '0;
    else if (pc_load)      pc <= pc_target;
    else if (pc_increment) pc <= pc + 16'd1;
  end

  always @(posedge clock) begin
    if (reset || !ifc.imem_req || ifc.imem_ack) wait_cnt <= 0;
    else                                        wait_cnt <= wait_cnt + 1;
  end

  assign ifc.imem_ack  = ifc.imem_req && (wait_cnt == ack_delay);
  assign ifc.imem_data = rom({1'b0, ifc.imem_addr});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every decode handshake must match the next expected fetch
  always @(negedge clock) begin
    if (!reset && ifc.instr_valid && ifc.instr_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got instr_pc %0h expected none", ifc.instr_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instr_pc", ifc.instr_pc, e.pc);
        check("sb_instr", ifc.instr, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget; i++) begin
      sample();
      if (ifc.imem_req) return;
      next_cycle();
    end
    check("wait_req_timeout", 32'(ifc.imem_req), 32'd1);
  endtask

  initial begin
    int reqs, incs;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 15'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 15'd0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 15'd1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 15'd1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 15'd2, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 15'd2, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 15'd3, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 15'd3, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 15'd4, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    jump = 1'b0;
    jump_target = '0;
    halt = 1'b0;
    ifc.instr_ready = 1'b1;
`ifdef HACK_FETCH_STEP_EN
    step = 1'b0;
`endif

    // Reset state
    sample();
    check("rst_pc_reset", pc_reset, 1'b1);
    check("rst_req", ifc.imem_req, 1'b0);
    check("rst_valid", ifc.instr_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_pc_target", pc_target, 16'h0);
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Zero-wait ROM, decode always ready
    for (int a = 0; a < 4; a++) sb.push_back(mk(16'(a)));
    for (int i = 0; i < 9; i++) begin
      ifc.instr_ready = vecs[i].ready;
      halt            = vecs[i].halt;
      sample();
      check($sformatf("v%0d_req", i), ifc.imem_req, vecs[i].exp_req);
      check($sformatf("v%0d_addr", i), ifc.imem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_valid", i), ifc.instr_valid, vecs[i].exp_valid);
      check($sformatf("v%0d_inc", i), pc_increment, vecs[i].exp_inc);
      check($sformatf("v%0d_load", i), pc_load, 1'b0);
      check($sformatf("v%0d_halted", i), halted, vecs[i].exp_halted);
      check($sformatf("v%0d_pc_reset", i), pc_reset, 1'b0);
      next_cycle();
    end

    // Fetch 4 zero-wait, then 3-cycle ack delay at address 5
    sb.push_back(mk(16'd4));
    next_cycle();
    ack_delay = 3;
    sb.push_back(mk(16'd5));
    next_cycle();
    reqs = 0;
    incs = 0;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (!ifc.imem_req) break;
      reqs++;
      check("slow_addr", ifc.imem_addr, 15'd5);
      if (pc_increment) incs++;
      next_cycle();
    end
    check("slow_req_cycles", reqs, 4);
    check("slow_inc_count", incs, 1);
    check("slow_valid", ifc.instr_valid, 1'b1);

    // Jump from HOLD at instr_pc 7
    ack_delay = 0;
    sb.push_back(mk(16'd6));
    next_cycle();
    next_cycle();
    next_cycle();
    ifc.instr_ready = 1'b0;
    next_cycle();
    jump = 1'b1;
    jump_target = 16'h0100;
    sample();
    check("hold_jmp_valid", ifc.instr_valid, 1'b1);
    check("hold_jmp_instr_pc", ifc.instr_pc, 16'd7);
    check("hold_jmp_instr", ifc.instr, rom(16'd7));
    check("hold_jmp_load", pc_load, 1'b1);
    check("hold_jmp_target", pc_target, 16'h0100);
    next_cycle();
    jump = 1'b0;
    ifc.instr_ready = 1'b1;
    sb.push_back(mk(16'h0100));
    sample();
    check("hold_jmp_valid_drop", ifc.instr_valid, 1'b0);
    check("hold_jmp_req", ifc.imem_req, 1'b1);
    check("hold_jmp_addr", ifc.imem_addr, 15'h0100);
    next_cycle();

    // Two jumps during a 4-cycle wait: the newer one wins, data dropped
    ack_delay = 3;
    next_cycle();
    jump = 1'b1;
    jump_target = 16'h0200;
    sample();
    check("fj_w0_addr", ifc.imem_addr, 15'h0101);
    check("fj_w0_load", pc_load, 1'b0);
    next_cycle();
    jump = 1'b0;
    next_cycle();
    jump = 1'b1;
    jump_target = 16'h0300;
    sample();
    check("fj_w2_load", pc_load, 1'b0);
    next_cycle();
    jump = 1'b0;
    sample();
    check("fj_ack_load", pc_load, 1'b1);
    check("fj_ack_target", pc_target, 16'h0300);
    check("fj_ack_inc", pc_increment, 1'b0);
    next_cycle();
    ack_delay = 0;
    sb.push_back(mk(16'h0300));
    sample();
    check("fj_no_hold", ifc.instr_valid, 1'b0);
    check("fj_new_req", ifc.imem_req, 1'b1);
    check("fj_new_addr", ifc.imem_addr, 15'h0300);
    next_cycle();

    // Halt raised mid-fetch: fetch completes, then HALT, then resume at pc+1
    ack_delay = 2;
    sb.push_back(mk(16'h0301));
    next_cycle();
    halt = 1'b1;
    sample();
    check("hf_req", ifc.imem_req, 1'b1);
    check("hf_halted", halted, 1'b0);
    next_cycle();
    next_cycle();
    next_cycle();
    sample();
    check("hf_hold_valid", ifc.instr_valid, 1'b1);
    next_cycle();
    sample();
    check("hf_halted_1", halted, 1'b1);
    check("hf_req_off", ifc.imem_req, 1'b0);
    next_cycle();
    ack_delay = 0;
    halt = 1'b0;
    sample();
    check("hf_halted_2", halted, 1'b1);
    next_cycle();
    sb.push_back(mk(16'h0302));
    sample();
    check("hf_resume_req", ifc.imem_req, 1'b1);
    check("hf_resume_addr", ifc.imem_addr, 15'h0302);
    check("hf_resume_halted", halted, 1'b0);
    next_cycle();

`ifdef HACK_FETCH_STEP_EN
    // Single step from HALT yields exactly one instruction
    halt = 1'b1;
    next_cycle();
    sample();
    check("st_halted", halted, 1'b1);
    next_cycle();
    step = 1'b1;
    sb.push_back(mk(16'h0303));
    next_cycle();
    step = 1'b0;
    sample();
    check("st_req", ifc.imem_req, 1'b1);
    check("st_addr", ifc.imem_addr, 15'h0303);
    next_cycle();
    next_cycle();
    sample();
    check("st_back_halted", halted, 1'b1);
    check("st_back_req", ifc.imem_req, 1'b0);
    halt = 1'b0;
    next_cycle();
`endif

    // Reset asserted mid-fetch
    ack_delay = 5;
    wait_req(10);
    check("mr_valid_pre", ifc.instr_valid, 1'b0);
    next_cycle();
    reset = 1'b1;
    sample();
    check("mr_pc_reset", pc_reset, 1'b1);
    check("mr_load", pc_load, 1'b0);
    check("mr_inc", pc_increment, 1'b0);
    next_cycle();
    sample();
    check("mr_idle_req", ifc.imem_req, 1'b0);
    check("mr_idle_valid", ifc.instr_valid, 1'b0);
    check("mr_idle_pc_reset", pc_reset, 1'b1);
    check("mr_idle_target", pc_target, 16'h0);
    next_cycle();
    reset = 1'b0;
    ack_delay = 0;
    sample();
    check("mr_rel_req", ifc.imem_req, 1'b0);
    sb.push_back(mk(16'h0));
    next_cycle();
    sample();
    check("mr_restart_req", ifc.imem_req, 1'b1);
    check("mr_restart_addr", ifc.imem_addr, 15'h0);
    next_cycle();
    next_cycle();
    sample();
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
